// File: rtl/job_arbiter_if.sv
// Requester and datapath signals of the job arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
// Combinational bundle only: no latency and no flow control of its own.
interface job_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [7:0]  req_on;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        err;
    logic [7:0]  dp_x;
    logic [1:0]  dp_on;
    logic        dp_start;
    logic        dp_active;
    logic [7:0]  dp_y;
    logic        busy;

    modport slave (
        input  req, req_x, req_on, dp_active, dp_y,
        output grant, done, result, err, dp_x, dp_on, dp_start, busy
    );

    modport master (
        output req, req_x, req_on, dp_active, dp_y,
        input  grant, done, result, err, dp_x, dp_on, dp_start, busy
    );
endinterface

// File: rtl/job_arbiter.sv
// Round-robin arbiter that hands one of four requesters' jobs to a shared datapath.
// Latency: grant 1 cycle after req; done at LAUNCH + 1 + k + n + 1 for a datapath active k..k+n.
// Backpressure: req is level-sensitive and simply waits while a job is in flight.
module job_arbiter #(
    parameter int TIMEOUT_MAX = 255,
    parameter int START_WAIT  = 4
) (
    input logic         clk,
    input logic         rst,
    job_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACT, RUN, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(START_WAIT - 1);
    localparam logic [7:0] RUN_LIMIT = 8'(TIMEOUT_MAX);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  x_q, x_d;
    logic [1:0]  on_q, on_d;
    logic        err_q, err_d;
    logic [7:0]  result_q, result_d;
    logic [2:0]  wait_q, wait_d;
    logic [7:0]  run_q, run_d;

    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic [7:0]  run_inc;

    // Scan from the requester after the last one served, so the previous owner goes last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        x_d      = x_q;
        on_d     = on_q;
        err_d    = err_q;
        result_d = result_q;
        wait_d   = wait_q;
        run_d    = run_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    x_d     = bus.req_x[{pick_idx, 3'b000} +: 8];
                    on_d    = bus.req_on[{pick_idx, 1'b0} +: 2];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_d  = '0;
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (bus.dp_active) begin
                    run_d   = '0;
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            RUN: begin
                run_d = run_inc;
                if (!bus.dp_active) begin
                    result_d = bus.dp_y;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (run_inc >= RUN_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = idx_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= 2'd3;
            x_q      <= '0;
            on_q     <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            wait_q   <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            x_q      <= x_d;
            on_q     <= on_d;
            err_q    <= err_d;
            result_q <= result_d;
            wait_q   <= wait_d;
            run_q    <= run_d;
        end
    end

    // All outputs decode from registered state, so reset clears them without a clock.
    assign bus.grant    = (state_q != IDLE) ? (4'b0001 << idx_q) : 4'b0000;
    assign bus.done     = (state_q == DONE) ? (4'b0001 << idx_q) : 4'b0000;
    assign bus.err      = (state_q == DONE) && err_q;
    assign bus.result   = result_q;
    assign bus.dp_x     = (state_q != IDLE) ? x_q : 8'h00;
    assign bus.dp_on    = (state_q != IDLE) ? on_q : 2'b00;
    assign bus.dp_start = (state_q == LAUNCH);
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_job_arbiter.sv
// Directed bench for job_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_job_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;

    job_arbiter_if bus ();

    job_arbiter #(.TIMEOUT_MAX(10), .START_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] rx;
        logic [7:0]  ron;
        logic        act;
        logic [7:0]  y;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic [7:0]  result;
        logic        err;
        logic        start;
        logic [7:0]  dpx;
        logic [1:0]  dpon;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] rq, input logic [31:0] rx, input logic [7:0] ron,
                       input logic act, input logic [7:0] y, input logic [3:0] g,
                       input logic [3:0] d, input logic [7:0] res, input logic e,
                       input logic st, input logic [7:0] dx, input logic [1:0] don,
                       input logic b);
        vec_t v;
        v.req = rq; v.rx = rx; v.ron = ron; v.act = act; v.y = y;
        v.grant = g; v.done = d; v.result = res; v.err = e; v.start = st;
        v.dpx = dx; v.dpon = don; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " grant"},    32'(bus.grant),    32'(v.grant));
        chk({tag, " done"},     32'(bus.done),     32'(v.done));
        chk({tag, " result"},   32'(bus.result),   32'(v.result));
        chk({tag, " err"},      32'(bus.err),      32'(v.err));
        chk({tag, " dp_start"}, 32'(bus.dp_start), 32'(v.start));
        chk({tag, " dp_x"},     32'(bus.dp_x),     32'(v.dpx));
        chk({tag, " dp_on"},    32'(bus.dp_on),    32'(v.dpon));
        chk({tag, " busy"},     32'(bus.busy),     32'(v.busy));
    endtask

    localparam logic [31:0] RXA = 32'h0000_005A;
    localparam logic [31:0] RXB = 32'h0000_3C00;

    initial begin
        vec_t zero;
        logic [3:0] exp_g;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.req = '0; bus.req_x = '0; bus.req_on = '0; bus.dp_active = 1'b0; bus.dp_y = '0;

        // Job A on requester 0: active one cycle late for three cycles, y = A5.
        add(4'b0001, RXA, 8'h02, 0, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 2'd0, 0);
        add(4'b0001, RXA, 8'h02, 0, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 1, 8'h5A, 2'd2, 1);
        add(4'b0110, RXA, 8'h02, 0, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b1110, RXA, 8'h02, 1, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b0000, RXA, 8'h02, 1, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b0000, RXA, 8'h02, 1, 8'h00, 4'b0001, 4'b0000, 8'h00, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b0000, RXA, 8'h02, 0, 8'hA5, 4'b0001, 4'b0000, 8'h00, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b0000, RXA, 8'h02, 0, 8'h00, 4'b0001, 4'b0001, 8'hA5, 0, 0, 8'h5A, 2'd2, 1);
        add(4'b0000, RXA, 8'h02, 0, 8'h00, 4'b0000, 4'b0000, 8'hA5, 0, 0, 8'h00, 2'd0, 0);
        // Job B on requester 1: datapath never activates, abort after START_WAIT cycles.
        add(4'b0010, RXB, 8'h0C, 0, 8'h00, 4'b0000, 4'b0000, 8'hA5, 0, 0, 8'h00, 2'd0, 0);
        add(4'b0010, RXB, 8'h0C, 0, 8'h00, 4'b0010, 4'b0000, 8'hA5, 0, 1, 8'h3C, 2'd3, 1);
        for (int i = 0; i < 4; i++)
            add(4'b0010, RXB, 8'h0C, 0, 8'h77, 4'b0010, 4'b0000, 8'hA5, 0, 0, 8'h3C, 2'd3, 1);
        add(4'b0000, RXB, 8'h0C, 0, 8'h00, 4'b0010, 4'b0010, 8'hA5, 1, 0, 8'h3C, 2'd3, 1);
        add(4'b0000, RXB, 8'h0C, 0, 8'h00, 4'b0000, 4'b0000, 8'hA5, 0, 0, 8'h00, 2'd0, 0);

        // Reset state.
        zero = '{default: '0};
        #3;
        chk_all("reset", zero);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.req = vq[i].req; bus.req_x = vq[i].rx; bus.req_on = vq[i].ron;
            bus.dp_active = vq[i].act; bus.dp_y = vq[i].y;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i]);
        end

        // dp_active high in IDLE must not start anything.
        @(negedge clk);
        bus.req = 4'b0000; bus.dp_active = 1'b1; bus.req_x = 32'h0077_9900; bus.req_on = 8'h14;
        #1 chk("idle_active busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        bus.req = 4'b0100;
        #1 chk("idle_active busy2", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #1;
        chk("to grant",    32'(bus.grant),    32'h4);
        chk("to dp_start", 32'(bus.dp_start), 32'h1);
        chk("to dp_x",     32'(bus.dp_x),     32'h77);
        chk("to dp_on",    32'(bus.dp_on),    32'h1);
        // Active held high: one WAIT_ACT cycle, ten RUN cycles, then DONE.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (bus.done == 4'b0000 && n < 40);
        chk("to latency", 32'(n),          32'd12);
        chk("to done",    32'(bus.done),   32'h4);
        chk("to err",     32'(bus.err),    32'h1);
        chk("to result",  32'(bus.result), 32'hA5);

        // Requester 1 drops req mid-run while requester 2 waits.
        @(negedge clk);
        bus.dp_active = 1'b0; bus.req = 4'b0110; bus.req_x = 32'h0044_9900; bus.req_on = 8'h14;
        #1;
        chk("to idle grant", 32'(bus.grant), 32'h0);
        chk("to idle busy",  32'(bus.busy),  32'h0);
        chk("to idle err",   32'(bus.err),   32'h0);
        @(negedge clk);
        #1;
        chk("drop grant", 32'(bus.grant), 32'h2);
        chk("drop dp_x",  32'(bus.dp_x),  32'h99);
        @(negedge clk);
        bus.dp_active = 1'b1;
        @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        bus.dp_active = 1'b0; bus.dp_y = 8'hC3;
        #1 chk("drop run grant", 32'(bus.grant), 32'h2);
        @(negedge clk);
        bus.dp_y = 8'h00;
        #1;
        chk("drop done",   32'(bus.done),   32'h2);
        chk("drop result", 32'(bus.result), 32'hC3);
        chk("drop err",    32'(bus.err),    32'h0);
        @(negedge clk);
        #1 chk("drop idle grant", 32'(bus.grant), 32'h0);
        @(negedge clk);
        #1;
        chk("next grant", 32'(bus.grant), 32'h4);
        chk("next dp_x",  32'(bus.dp_x),  32'h44);
        @(negedge clk);
        bus.dp_active = 1'b1;
        @(negedge clk);
        // Now in RUN; reset asynchronously between edges.
        #2 rst = 1'b0;
        #1;
        chk_all("midrst", zero);
        bus.req = 4'b1111; bus.dp_active = 1'b0;
        @(negedge clk);
        #1;
        chk_all("midrst held", zero);
        rst = 1'b1;

        // All four requesting: strict rotation starting at 0, IDLE between jobs.
        for (int j = 0; j < 5; j++) begin
            exp_g = 4'b0001 << (j % 4);
            n = 0;
            while (bus.grant == 4'b0000 && n < 20) begin
                @(negedge clk);
                #1;
                chk($sformatf("rr%0d no done", j), 32'(bus.done), 32'h0);
                n++;
            end
            chk($sformatf("rr%0d grant", j), 32'(bus.grant), 32'(exp_g));
            n = 0;
            while (bus.done == 4'b0000 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("rr%0d done", j), 32'(bus.done), 32'(exp_g));
            chk($sformatf("rr%0d err", j),  32'(bus.err),  32'h1);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d gap grant", j), 32'(bus.grant), 32'h0);
            chk($sformatf("rr%0d gap busy", j),  32'(bus.busy),  32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
